// File: rtl/dm_responder.sv
// dm_responder: data-memory end of the M-stage load/store interface.
// Accepts one request at a time, holds it for LATENCY wait cycles, then
// commits it (store with byte enables, or full-word load) and pulses
// resp_valid for one cycle. Invalid requests complete with resp_err.
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-low reset
//   req_valid   request present from the M stage
//   req_ready   responder can accept this cycle (IDLE)
//   req_we      1 = store, 0 = load
//   req_be      byte-lane enables for stores
//   req_addr    byte address
//   req_wdata   lane-aligned store data
//   resp_valid  one-cycle response pulse
//   resp_rdata  loaded word (0 for stores and errors)
//   resp_err    request rejected, qualified by resp_valid
//   busy        stall request to hazard logic
module dm_responder #(
    parameter int unsigned DEPTH_WORDS = 3072,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_e;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              we_q;
    logic [3:0]        be_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;
    logic [31:0]       mem_q [DEPTH_WORDS];

    // Request being committed: the live inputs when LATENCY==0 commits on
    // the accept edge, otherwise the latched copy.
    logic              c_we;
    logic [3:0]        c_be;
    logic [31:0]       c_addr;
    logic [31:0]       c_wdata;
    logic              range_err;
    logic              be_ok;
    logic [1:0]        lane_lo;
    logic              c_err;
    logic [AW-1:0]     c_idx;
    logic [31:0]       cur_word;
    logic [31:0]       merged;
    logic              commit;

    // Error classification and merged store word for the committing request
    always_comb begin
        c_we     = we_q;
        c_be     = be_q;
        c_addr   = addr_q;
        c_wdata  = wdata_q;
        be_ok    = 1'b1;
        lane_lo  = 2'd0;
        merged   = '0;
        if (state_q == S_IDLE) begin
            c_we    = req_we;
            c_be    = req_be;
            c_addr  = req_addr;
            c_wdata = req_wdata;
        end

        range_err = ({2'b00, c_addr[31:2]} >= 32'(DEPTH_WORDS));

        // Legal store shapes and the byte lane each must start on
        case (c_be)
            4'b0001: lane_lo = 2'd0;
            4'b0010: lane_lo = 2'd1;
            4'b0100: lane_lo = 2'd2;
            4'b1000: lane_lo = 2'd3;
            4'b0011: lane_lo = 2'd0;
            4'b1100: lane_lo = 2'd2;
            4'b1111: lane_lo = 2'd0;
            default: be_ok   = 1'b0;
        endcase

        c_err    = range_err || (c_we && (!be_ok || (c_addr[1:0] != lane_lo)));
        c_idx    = range_err ? '0 : c_addr[AW+1:2];
        cur_word = mem_q[c_idx];

        for (int i = 0; i < 4; i++) begin
            merged[8*i +: 8] = c_be[i] ? c_wdata[8*i +: 8] : cur_word[8*i +: 8];
        end

        commit = ((state_q == S_IDLE) && req_valid && (LATENCY == 0)) ||
                 ((state_q == S_WAIT) && (cnt_q == '0));
    end

    // Control FSM, request latch, memory array and response registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH_WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            // Response fields are only non-zero during the RESP cycle
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;

            if (commit) begin
                resp_valid_q <= 1'b1;
                resp_err_q   <= c_err;
                if (!c_err) begin
                    if (c_we) begin
                        mem_q[c_idx] <= merged;
                    end else begin
                        resp_rdata_q <= cur_word;
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        be_q    <= req_be;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        if (LATENCY == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= CNT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == '0) begin
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    // Combinational so the CPU can stall in the same cycle it raises req_valid
    assign busy       = (state_q != S_IDLE) || req_valid;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: one LATENCY=2 and one LATENCY=0
// instance share the request bus so both see identical traffic.
module tb_dm_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [3:0]  req_be;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        rdy2, rv2, er2, bz2;
    logic [31:0] rd2;
    logic        rdy0, rv0, er0, bz0;
    logic [31:0] rd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(2)) u_lat2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy2), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv2), .resp_rdata(rd2), .resp_err(er2), .busy(bz2)
    );

    dm_responder #(.DEPTH_WORDS(3072), .LATENCY(0)) u_lat0 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(rdy0), .req_we(req_we),
        .req_be(req_be), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0), .busy(bz0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One request through both instances. The LATENCY=2 response must be
    // sampled on the 3rd edge after the accept edge, LATENCY=0 on the 1st.
    task automatic txn(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err);
        int  n;
        bit  seen;
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = we;
        req_be    = be;
        req_addr  = addr;
        req_wdata = wd;
        #1;
        chk({tag, ".busy_pre"}, 32'(bz2), 32'd1);
        chk({tag, ".ready_pre"}, 32'(rdy2), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, ".l0_valid"}, 32'(rv0), 32'd1);
        chk({tag, ".l0_rdata"}, rd0, exp_rd);
        chk({tag, ".l0_err"}, 32'(er0), 32'(exp_err));
        chk({tag, ".l2_ready_wait"}, 32'(rdy2), 32'd0);
        chk({tag, ".l2_busy_wait"}, 32'(bz2), 32'd1);
        n    = 1;
        seen = 1'b0;
        while (!seen && n < 10) begin
            if (rv2) begin
                seen = 1'b1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk({tag, ".l2_seen"}, 32'(seen), 32'd1);
        chk({tag, ".l2_edge"}, 32'(n), 32'd3);
        chk({tag, ".l2_rdata"}, rd2, exp_rd);
        chk({tag, ".l2_err"}, 32'(er2), 32'(exp_err));
        @(negedge clk);
        chk({tag, ".l2_valid_drop"}, 32'(rv2), 32'd0);
        chk({tag, ".l2_rdata_drop"}, rd2, 32'd0);
        chk({tag, ".l2_err_drop"}, 32'(er2), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, p2;
        int pos [3];
        rst       = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_be    = 4'b0000;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst.valid", 32'(rv2), 32'd0);
        chk("rst.rdata", rd2, 32'd0);
        chk("rst.err", 32'(er2), 32'd0);
        chk("rst.ready", 32'(rdy2), 32'd1);
        chk("rst.busy", 32'(bz2), 32'd0);
        chk("rst.l0_valid", 32'(rv0), 32'd0);
        rst = 1'b1;

        txn("st_word",   1'b1, 4'b1111, 32'h10,   32'h12345678, 32'h0,        1'b0);
        txn("ld_word",   1'b0, 4'b0000, 32'h10,   32'h0,        32'h12345678, 1'b0);
        txn("st_byte3",  1'b1, 4'b1000, 32'h13,   32'hAB000000, 32'h0,        1'b0);
        txn("ld_byte3",  1'b0, 4'b1111, 32'h10,   32'h0,        32'hAB345678, 1'b0);
        txn("st_half_mis", 1'b1, 4'b0011, 32'h12, 32'h0000BEEF, 32'h0,        1'b1);
        txn("ld_after_mis", 1'b0, 4'b0000, 32'h10, 32'h0,       32'hAB345678, 1'b0);
        txn("st_be0101", 1'b1, 4'b0101, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1);
        txn("st_be0000", 1'b1, 4'b0000, 32'h10,   32'hFFFFFFFF, 32'h0,        1'b1);
        txn("st_half_hi", 1'b1, 4'b1100, 32'h12,  32'h55660000, 32'h0,        1'b0);
        txn("ld_half_hi", 1'b0, 4'b0000, 32'h11,  32'h0,        32'h55665678, 1'b0);
        txn("ld_oor",    1'b0, 4'b0000, 32'h3000, 32'h0,        32'h0,        1'b1);
        txn("st_oor",    1'b1, 4'b1111, 32'h3000, 32'h11111111, 32'h0,        1'b1);
        txn("st_last",   1'b1, 4'b1111, 32'h2FFC, 32'hCAFEF00D, 32'h0,        1'b0);
        txn("ld_last",   1'b0, 4'b0000, 32'h2FFC, 32'h0,        32'hCAFEF00D, 1'b0);

        // req_valid held across three LATENCY=0 round trips
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_be    = 4'b1111;
        req_addr  = 32'h10;
        p0 = 0;
        p2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (rv0) begin
                if (p0 < 3) pos[p0] = k;
                p0++;
                chk("b2b.l0_rdata", rd0, 32'h55665678);
            end
            if (rv2) p2++;
            if (k == 4) req_valid = 1'b0;
        end
        chk("b2b.l0_pulses", 32'(p0), 32'd3);
        if (p0 == 3) begin
            chk("b2b.gap01", 32'(pos[1] - pos[0]), 32'd2);
            chk("b2b.gap12", 32'(pos[2] - pos[1]), 32'd2);
        end
        chk("b2b.l2_pulses", 32'(p2), 32'd2);
        chk("b2b.l2_idle", 32'(rdy2), 32'd1);

        // Reset while the LATENCY=2 store is waiting
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_be    = 4'b1111;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        rst       = 1'b0;
        p2 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 1) rst = 1'b1;
            if (rv2) p2++;
        end
        chk("rstw.pulses", 32'(p2), 32'd0);
        chk("rstw.ready", 32'(rdy2), 32'd1);
        txn("rstw.ld20", 1'b0, 4'b0000, 32'h20, 32'h0, 32'h0, 1'b0);
        txn("rstw.ld10", 1'b0, 4'b0000, 32'h10, 32'h0, 32'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
